// File: rtl/aq_djpeg_byte_window.sv
// Byte-aligning input window for the JPEG header parser.
// Accepts 32-bit big-endian stream words and keeps up to 8 bytes left-justified
// in a 64-bit buffer. The upper 32 bits form the parser window. The parser pops
// 1 or 2 bytes per cycle. End-of-stream is flagged once the final word is drained.
// Optional build macro AQ_DJPEG_BYTE_WINDOW_STAT_EN adds a saturating ByteTotal
// counter of consumed bytes.

module aq_djpeg_byte_window (
  input  logic        clk,
  input  logic        rst,
  input  logic        Clear,
  input  logic [31:0] InData,
  input  logic [3:0]  InKeep,
  input  logic        InLast,
  input  logic        InValid,
  output logic        InReady,
  output logic [31:0] DataIn,
  output logic        DataInEnable,
  output logic        DataInEnd,
`ifdef AQ_DJPEG_BYTE_WINDOW_STAT_EN
  output logic [31:0] ByteTotal,
`endif
  input  logic        UseByte,
  input  logic        UseWord
);

  typedef enum logic [1:0] {
    StFill,
    StDrain,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] win_q, win_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        end_q, end_d;

  logic        accept;
  logic [3:0]  use_n;
  logic [3:0]  keep_k;
  logic [3:0]  add_k;
  logic [3:0]  base_pos;
  logic [3:0]  cnt_nx;
  logic [31:0] in_mask;
  logic [63:0] ins_word;
  logic [63:0] fill_mask;
  logic [63:0] win_nx;

  // Ready depends only on registered state and Clear, never on InValid.
  assign InReady = (state_q == StFill) && (cnt_q <= 4'd4) && !Clear;
  assign accept  = InValid & InReady;

  // Consume amount: UseWord wins, ignored while the window is unusable, clamped to fill level.
  always_comb begin
    use_n = 4'd0;
    if (en_q) begin
      if (UseWord) begin
        use_n = 4'd2;
      end else if (UseByte) begin
        use_n = 4'd1;
      end
    end
    if (use_n > cnt_q) begin
      use_n = cnt_q;
    end
  end

  // Number of valid bytes in the incoming word (contiguous from the MSB).
  always_comb begin
    case (InKeep)
      4'b1111: keep_k = 4'd4;
      4'b1110: keep_k = 4'd3;
      4'b1100: keep_k = 4'd2;
      4'b1000: keep_k = 4'd1;
      default: keep_k = 4'd0;
    endcase
  end

  // Position (in bytes from the MSB) where new bytes land after this cycle's consume.
  assign base_pos = cnt_q - use_n;

  // Drop the don't-care bytes of a partial word so they cannot leak into the window.
  assign in_mask = ~(32'hFFFF_FFFF >> {keep_k, 3'b000});

  // Align the accepted bytes right behind the surviving buffered bytes.
  always_comb begin
    ins_word = 64'h0;
    add_k    = 4'd0;
    if (accept) begin
      ins_word = {InData & in_mask, 32'h0} >> {base_pos, 3'b000};
      add_k    = keep_k;
    end
  end

  assign cnt_nx    = base_pos + add_k;
  // Bytes at or beyond the new fill level read as zero; this also zero-pads a short tail.
  assign fill_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {cnt_nx, 3'b000});
  assign win_nx    = ((win_q << {use_n, 3'b000}) | ins_word) & fill_mask;

  // Next-state for buffer, fill count, FSM and registered status outputs.
  always_comb begin
    state_d = state_q;
    win_d   = win_nx;
    cnt_d   = cnt_nx;

    if (Clear) begin
      state_d = StFill;
      win_d   = 64'h0;
      cnt_d   = 4'd0;
    end else begin
      case (state_q)
        StFill: begin
          if (accept && InLast) begin
            state_d = (cnt_nx == 4'd0) ? StDone : StDrain;
          end
        end
        StDrain: begin
          if (cnt_nx == 4'd0) begin
            state_d = StDone;
          end
        end
        default: begin
          // StDone holds until Clear.
          state_d = StDone;
        end
      endcase
    end

    case (state_d)
      StFill:  en_d = (cnt_d >= 4'd4);
      StDrain: en_d = (cnt_d != 4'd0);
      default: en_d = 1'b0;
    endcase
    end_d = (state_d == StDone);
  end

  // Buffer, count, FSM state and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StFill;
      win_q   <= 64'h0;
      cnt_q   <= 4'd0;
      en_q    <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      end_q   <= end_d;
    end
  end

  assign DataIn       = win_q[63:32];
  assign DataInEnable = en_q;
  assign DataInEnd    = end_q;

`ifdef AQ_DJPEG_BYTE_WINDOW_STAT_EN
  logic [31:0] total_q, total_d;
  logic [32:0] total_sum;

  assign total_sum = {1'b0, total_q} + {29'h0, use_n};

  // Saturating count of consumed bytes; Clear suppresses consumption, so it just zeroes.
  always_comb begin
    total_d = total_q;
    if (Clear) begin
      total_d = 32'h0;
    end else if (total_sum[32]) begin
      total_d = 32'hFFFF_FFFF;
    end else begin
      total_d = total_sum[31:0];
    end
  end

  // Consumed-byte statistics register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_q <= 32'h0;
    end else begin
      total_q <= total_d;
    end
  end

  assign ByteTotal = total_q;
`endif

endmodule
